// File: rtl/reg_spill_fill.sv
// Spill/fill sequencer: copies a contiguous run of register-file entries to
// data memory or back, one register per cycle (spill) or per two cycles (fill).
module reg_spill_fill #(
  parameter int A = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         start,
  input  logic         dir,
  input  logic [A-1:0] first_reg,
  input  logic [A:0]   count,
  input  logic [W-1:0] mem_base,
  output logic         busy,
  output logic         done,
  output logic [A-1:0] rf_addr,
  input  logic [W-1:0] rf_rdata,
  output logic         rf_write_en,
  output logic         rf_from_mem,
  output logic [W-1:0] mem_addr,
  output logic         mem_wr_en,
  output logic [W-1:0] mem_wr_data,
  input  logic [W-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SPILL   = 3'd1;
  localparam logic [2:0] S_FILL_RD = 3'd2;
  localparam logic [2:0] S_FILL_WR = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [A:0] FULL = {1'b1, {A{1'b0}}};
  localparam logic [A:0] ONE  = (A+1)'(1);

  logic [2:0]   state;
  logic [A-1:0] cur_reg;
  logic [A:0]   remaining;
  logic [W-1:0] cur_mem;
  logic [A:0]   clamped;

  // Memory read data goes straight into the register file's write port; the
  // sequencer only steers addresses and strobes around it.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  assign clamped = (count > FULL) ? FULL : count;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      cur_reg   <= '0;
      remaining <= '0;
      cur_mem   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_reg   <= first_reg;
            remaining <= clamped;
            cur_mem   <= mem_base;
            if (clamped == '0) state <= S_FINISH;
            else               state <= dir ? S_FILL_RD : S_SPILL;
          end
        end
        S_SPILL: begin
          cur_reg   <= cur_reg + A'(1);
          cur_mem   <= cur_mem + W'(1);
          remaining <= remaining - ONE;
          if (remaining == ONE) state <= S_FINISH;
        end
        S_FILL_RD: state <= S_FILL_WR;
        S_FILL_WR: begin
          cur_reg   <= cur_reg + A'(1);
          cur_mem   <= cur_mem + W'(1);
          remaining <= remaining - ONE;
          state     <= (remaining == ONE) ? S_FINISH : S_FILL_RD;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state (plus rf_rdata on the spill data path).
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    rf_addr     = '0;
    rf_write_en = 1'b0;
    rf_from_mem = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      S_SPILL: begin
        busy        = 1'b1;
        rf_addr     = cur_reg;
        mem_addr    = cur_mem;
        mem_wr_en   = 1'b1;
        mem_wr_data = rf_rdata;
      end
      S_FILL_RD: begin
        busy     = 1'b1;
        mem_addr = cur_mem;
      end
      S_FILL_WR: begin
        busy        = 1'b1;
        rf_addr     = cur_reg;
        rf_write_en = 1'b1;
        rf_from_mem = 1'b1;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_spill_fill.sv
// Bench for reg_spill_fill: models the register file and data memory around the
// DUT and compares final contents and timing against a transfer-level model.
module tb_reg_spill_fill;
  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] first_reg = '0;
  logic [4:0] count = '0;
  logic [7:0] mem_base = '0;
  logic       busy, done, rf_write_en, rf_from_mem, mem_wr_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_rdata, mem_addr, mem_wr_data;
  logic [7:0] mem_rdata = '0;

  logic [7:0] rf [16];
  logic [7:0] mem [256];
  logic [7:0] ref_rf [16];
  logic [7:0] ref_mem [256];

  logic       bd_we = 1'b0, bd_sel = 1'b0;
  logic [7:0] bd_addr = '0, bd_data = '0;

  int tests = 0;
  int fails = 0;

  reg_spill_fill #(.A(4), .W(8)) dut (
    .clk(clk), .Reset(Reset), .start(start), .dir(dir), .first_reg(first_reg),
    .count(count), .mem_base(mem_base), .busy(busy), .done(done),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_write_en(rf_write_en),
    .rf_from_mem(rf_from_mem), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment: combinational-read register file, 1-cycle-latency memory.
  assign rf_rdata = rf[rf_addr];
  always @(posedge clk) begin
    if (bd_we) begin
      if (bd_sel) mem[bd_addr] <= bd_data;
      else        rf[bd_addr[3:0]] <= bd_data;
    end
    if (rf_write_en && rf_from_mem) rf[rf_addr] <= mem_rdata;
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rdata <= mem[mem_addr];
  end

  task automatic bd_write(input bit sel, input int a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_sel = sel; bd_addr = 8'(a); bd_data = d;
    if (sel) ref_mem[a % 256] = d; else ref_rf[a % 16] = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // One transfer: drive start, watch strobes cycle by cycle, then compare
  // timing/strobe counts and the whole register file and memory to the model.
  task automatic run_xfer(input bit d, input int first, input int cnt, input int base,
                          input int inject_at, input string name);
    int n, exp_done, done_at, pulses, mw, rw, bsy, both, consec, lim;
    bit prev_rw;
    n = (cnt > 16) ? 16 : cnt;
    exp_done = (d ? 2 * n : n) + 1;
    for (int i = 0; i < n; i++)
      if (d) ref_rf[(first + i) % 16] = ref_mem[(base + i) % 256];
      else   ref_mem[(base + i) % 256] = ref_rf[(first + i) % 16];
    done_at = 0; pulses = 0; mw = 0; rw = 0; bsy = 0; both = 0; consec = 0; prev_rw = 0;
    lim = exp_done + ((inject_at > 0) ? 3 : 0);
    @(negedge clk);
    start = 1'b1; dir = d; first_reg = 4'(first); count = 5'(cnt); mem_base = 8'(base);
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) bsy++;
      if (mem_wr_en) mw++;
      if (rf_write_en) rw++;
      if (mem_wr_en && rf_write_en) both++;
      if (rf_write_en && prev_rw) consec++;
      prev_rw = rf_write_en;
      if (done) begin pulses++; if (done_at == 0) done_at = k; end
      if (k == inject_at) begin
        start = 1'b1; dir = 1'($urandom_range(1)); first_reg = 4'($urandom_range(15));
        count = 5'($urandom_range(20, 1)); mem_base = 8'($urandom_range(255));
      end
      if (inject_at > 0 && k == inject_at + 1) start = 1'b0;
    end
    tests++; if (done_at !== exp_done) begin fails++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_at, exp_done); end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL %s done_pulses got %0d exp 1", name, pulses); end
    tests++; if (bsy !== exp_done - 1) begin fails++; $display("FAIL %s busy_cycles got %0d exp %0d", name, bsy, exp_done - 1); end
    tests++; if (mw !== (d ? 0 : n)) begin fails++; $display("FAIL %s mem_writes got %0d exp %0d", name, mw, d ? 0 : n); end
    tests++; if (rw !== (d ? n : 0)) begin fails++; $display("FAIL %s rf_writes got %0d exp %0d", name, rw, d ? n : 0); end
    tests++; if (both !== 0) begin fails++; $display("FAIL %s both_strobes got %0d exp 0", name, both); end
    tests++; if (consec !== 0) begin fails++; $display("FAIL %s consecutive_rf_writes got %0d exp 0", name, consec); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rf[i] !== ref_rf[i]) begin fails++; $display("FAIL %s rf[%0d] got %h exp %h", name, i, rf[i], ref_rf[i]); end
    end
    for (int i = 0; i < 256; i++) begin
      tests++;
      if (mem[i] !== ref_mem[i]) begin fails++; $display("FAIL %s mem[%0h] got %h exp %h", name, i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b1; count = 5'd4;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, rf_write_en, rf_from_mem, mem_wr_en} !== 5'b0) begin
      fails++; $display("FAIL reset strobes got %b exp 00000", {busy, done, rf_write_en, rf_from_mem, mem_wr_en});
    end
    tests++;
    if ({rf_addr, mem_addr, mem_wr_data} !== 20'h0) begin
      fails++; $display("FAIL reset addrs got %h exp 0", {rf_addr, mem_addr, mem_wr_data});
    end
    start = 1'b0; Reset = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset idle_busy got %b exp 0", busy); end
    for (int i = 0; i < 16; i++) bd_write(1'b0, i, 8'h00);
    for (int i = 0; i < 256; i++) bd_write(1'b1, i, 8'h00);
  endtask

  task automatic test_spill();
    bd_write(1'b0, 2, 8'h11); bd_write(1'b0, 3, 8'h22);
    bd_write(1'b0, 4, 8'h33); bd_write(1'b0, 5, 8'h44);
    run_xfer(1'b0, 2, 4, 8'h40, 0, "spill");
    tests++; if (mem[8'h43] !== 8'h44) begin fails++; $display("FAIL spill_last mem[43] got %h exp 44", mem[8'h43]); end
  endtask

  task automatic test_fill();
    bd_write(1'b1, 8'h80, 8'hA5); bd_write(1'b1, 8'h81, 8'h5A); bd_write(1'b1, 8'h82, 8'hFF);
    run_xfer(1'b1, 7, 3, 8'h80, 0, "fill");
    tests++; if (rf[8] !== 8'h5A) begin fails++; $display("FAIL fill_mid r8 got %h exp 5a", rf[8]); end
  endtask

  task automatic test_wrap();
    bd_write(1'b0, 14, 8'hE1); bd_write(1'b0, 15, 8'hF2);
    bd_write(1'b0, 0, 8'h03);  bd_write(1'b0, 1, 8'h14);
    run_xfer(1'b0, 14, 4, 8'hFE, 0, "wrap_spill");
    tests++; if (mem[0] !== 8'h03) begin fails++; $display("FAIL wrap_spill mem[00] got %h exp 03", mem[0]); end
    run_xfer(1'b1, 15, 3, 8'hFF, 0, "wrap_fill");
  endtask

  task automatic test_count_edges();
    for (int i = 0; i < 16; i++) bd_write(1'b0, i, 8'($urandom));
    run_xfer(1'b0, 5, 0, 8'h10, 0, "count0_spill");
    run_xfer(1'b1, 5, 0, 8'h10, 0, "count0_fill");
    run_xfer(1'b0, 9, 20, 8'hC0, 0, "count20_spill");
    run_xfer(1'b0, 3, 16, 8'h20, 0, "count16_spill");
    run_xfer(1'b1, 0, 31, 8'hC0, 0, "count31_fill");
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < 16; i++) bd_write(1'b0, i, 8'($urandom));
    run_xfer(1'b0, 1, 4, 8'h60, 2, "start_in_spill");
    run_xfer(1'b0, 6, 4, 8'h70, 5, "start_in_finish");
    run_xfer(1'b1, 8, 3, 8'h60, 3, "start_in_fill");
  endtask

  task automatic test_reset_mid();
    int seen_done, seen_wr;
    for (int i = 0; i < 4; i++) bd_write(1'b1, 8'h30 + i, 8'($urandom));
    for (int i = 0; i < 16; i++) bd_write(1'b0, i, 8'($urandom));
    ref_rf[4] = ref_mem[8'h30];
    @(negedge clk);
    start = 1'b1; dir = 1'b1; first_reg = 4'd4; count = 5'd4; mem_base = 8'h30;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) Reset = 1'b1;
    end
    @(negedge clk);
    tests++;
    if ({busy, done, rf_write_en, rf_from_mem, mem_wr_en} !== 5'b0) begin
      fails++; $display("FAIL reset_mid strobes got %b exp 00000", {busy, done, rf_write_en, rf_from_mem, mem_wr_en});
    end
    tests++;
    if ({rf_addr, mem_addr} !== 12'h0) begin fails++; $display("FAIL reset_mid addrs got %h exp 0", {rf_addr, mem_addr}); end
    Reset = 1'b0;
    seen_done = 0; seen_wr = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done++;
      if (rf_write_en || mem_wr_en || busy) seen_wr++;
    end
    tests++; if (seen_done !== 0) begin fails++; $display("FAIL reset_mid done_after got %0d exp 0", seen_done); end
    tests++; if (seen_wr !== 0) begin fails++; $display("FAIL reset_mid activity_after got %0d exp 0", seen_wr); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rf[i] !== ref_rf[i]) begin fails++; $display("FAIL reset_mid rf[%0d] got %h exp %h", i, rf[i], ref_rf[i]); end
    end
    run_xfer(1'b1, 4, 4, 8'h30, 0, "after_reset_fill");
  endtask

  task automatic test_back_to_back();
    int f, c, b;
    bit d;
    for (int i = 0; i < 16; i++) bd_write(1'b0, i, 8'($urandom));
    for (int i = 0; i < 32; i++) bd_write(1'b1, $urandom_range(255), 8'($urandom));
    for (int t = 0; t < 10; t++) begin
      d = 1'($urandom_range(1)); f = $urandom_range(15); c = $urandom_range(20); b = $urandom_range(255);
      run_xfer(d, f, c, b, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_spill();
    test_fill();
    test_wrap();
    test_count_edges();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
